// File: rtl/vector_dram_wait_shell.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// vector_dram_wait_shell
//
// Purpose:
//   Single-port wide-word memory shell with a fixed number of wait states.
//   It accepts one request at a time (IDLE -> [WAIT] -> RESP -> IDLE).
//   The memory access happens on the edge entering RESP. A one-cycle
//   resp_valid pulse then reports completion.
//
// Parameters:
//   DATA_W     - data word width in bits (power of two, >= 8)
//   ADDR_W     - byte-address width
//   DEPTH_LOG2 - memory holds 2**DEPTH_LOG2 words
//   WAIT_CYC   - wait states per access (0..15)
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_b      in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  request accepted this cycle (high only in IDLE)
//   rw         in   1 = read, 0 = write
//   addr       in   byte address, bit 0 = MSB
//   data_in    in   write data, bit 0 = MSB
//   write_en   in   byte enables, bit i covers data_in[8i:8i+7]
//   resp_valid out  one-cycle response pulse
//   data_out   out  read data (0 unless a good read response)
//   err        out  out-of-range flag, qualified by resp_valid
//
// Configuration macro:
//   VDRAM_RANGE_CHECK_EN - when defined, an access whose word index has
//   any bit set at or above DEPTH_LOG2 is rejected with err. Otherwise the
//   index wraps and err is tied low.
// -----------------------------------------------------------------------------
module vector_dram_wait_shell #(
    parameter int DATA_W     = 128,
    parameter int ADDR_W     = 32,
    parameter int DEPTH_LOG2 = 12,
    parameter int WAIT_CYC   = 0
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                rw,
    input  logic [0:ADDR_W-1]   addr,
    input  logic [0:DATA_W-1]   data_in,
    input  logic [DATA_W/8-1:0] write_en,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   data_out,
    output logic                err
);
    localparam int NBYTES = DATA_W / 8;
    localparam int OFF_W  = $clog2(NBYTES);
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                r_state, w_state_next;
    logic [3:0]            r_cnt, w_cnt_next;

    // Captured request
    logic                  r_rw;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_data;
    logic [NBYTES-1:0]     r_we;

    // Access operands
    logic                  w_accept;
    logic                  w_access;
    logic                  w_rw;
    logic                  w_oor;
    logic [ADDR_W-1:0]     w_addr_in, w_addr;
    logic [DATA_W-1:0]     w_data_in, w_data;
    logic [NBYTES-1:0]     w_we, w_be;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_unused_addr;

    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [DATA_W-1:0]     r_rd_data;

    // Re-express the MSB-first input vectors as ordinary descending vectors
    // (numeric value is unchanged).
    assign w_addr_in = addr;
    assign w_data_in = data_in;

    assign w_accept = req_valid && (r_state == IDLE);

    // With zero wait states the access happens on the accepting edge itself,
    // before the capture registers are loaded, so the live inputs are used
    // while in IDLE and the captured copy afterwards.
    assign w_rw   = (r_state == IDLE) ? rw        : r_rw;
    assign w_addr = (r_state == IDLE) ? w_addr_in : r_addr;
    assign w_data = (r_state == IDLE) ? w_data_in : r_data;
    assign w_we   = (r_state == IDLE) ? write_en  : r_we;

    assign w_idx  = w_addr[OFF_W +: DEPTH_LOG2];

    // Byte offset bits never address anything; the upper bits only matter
    // when range checking is built in.
    assign w_unused_addr = ^w_addr;

`ifdef VDRAM_RANGE_CHECK_EN
    assign w_oor = |(w_addr >> (OFF_W + DEPTH_LOG2));
`else
    assign w_oor = 1'b0;
`endif

    // write_en bit 0 names the most significant byte; flip to LSB-first
    // so byte j of the stored word maps to w_be[j].
    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_be
            assign w_be[gi] = w_we[NBYTES-1-gi];
        end
    endgenerate

    // Access fires on the edge entering RESP; rst_b is included so that a
    // request arriving while reset is held never touches memory.
    assign w_access = rst_b && (w_state_next == RESP) && (r_state != RESP);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYC == 0) begin
                        w_state_next = RESP;
                    end else begin
                        w_state_next = WAIT;
                        w_cnt_next   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = RESP;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_rw    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_we    <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_rw   <= rw;
                r_addr <= w_addr_in;
                r_data <= w_data_in;
                r_we   <= write_en;
            end
        end
    end

    // Memory array: not reset, byte-enabled write, registered read.
    always_ff @(posedge clk) begin
        if (w_access && !w_oor) begin
            if (w_rw) begin
                r_rd_data <= r_mem[w_idx];
            end else begin
                for (int b = 0; b < NBYTES; b++) begin
                    if (w_be[b]) begin
                        r_mem[w_idx][8*b +: 8] <= w_data[8*b +: 8];
                    end
                end
            end
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign err        = resp_valid && w_oor;
    assign data_out   = (resp_valid && r_rw && !w_oor) ? r_rd_data : '0;

endmodule
